// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter in front of a shared bank of W-bit registers, one registered read port.
// Optional write-first read bypass when REGFILE_ARB_BYPASS_EN is defined.
module regfile_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [W-1:0]      rd_data,
    output logic              wr_valid,
    output logic [2:0]        wr_id,
    output logic [AW-1:0]     wr_addr
);

    localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

    logic [W-1:0]    regs [NREGS];
    logic [2:0]      rr_ptr;
    logic [2:0]      gnt_idx;
    logic [2:0]      ptr_next;
    logic            gnt_any;
    logic [NREQ-1:0] gnt_vec;
    logic [AW-1:0]   gnt_addr;
    logic [W-1:0]    gnt_data;
    logic            gnt_in_range;
    logic            rd_in_range;
    logic [W-1:0]    rd_next;

    // Scan from rr_ptr upward (mod NREQ); the first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = 3'((int'(rr_ptr) + k) % NREQ);
                gnt_vec = NREQ'(1) << ((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign req_ready    = rst_n ? gnt_vec : '0;
    assign gnt_addr     = req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data     = req_data[int'(gnt_idx)*W +: W];
    assign gnt_in_range = ({1'b0, gnt_addr} < NREGS_L);
    assign rd_in_range  = ({1'b0, rd_addr} < NREGS_L);
    assign ptr_next     = 3'((int'(gnt_idx) + 1) % NREQ);

`ifdef REGFILE_ARB_BYPASS_EN
    // Write-first: a same-edge write to the read address is forwarded.
    always_comb begin
        rd_next = '0;
        if (gnt_any && gnt_in_range && (gnt_addr == rd_addr)) rd_next = gnt_data;
        else if (rd_in_range)                                  rd_next = regs[rd_addr];
    end
`else
    always_comb begin
        rd_next = '0;
        if (rd_in_range) rd_next = regs[rd_addr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rr_ptr   <= '0;
            rd_data  <= '0;
            wr_valid <= 1'b0;
            wr_id    <= '0;
            wr_addr  <= '0;
        end else begin
            rd_data <= rd_next;
            if (gnt_any) begin
                // Out-of-range targets still complete the handshake but change nothing.
                if (gnt_in_range) regs[gnt_addr] <= gnt_data;
                rr_ptr   <= ptr_next;
                wr_valid <= 1'b1;
                wr_id    <= gnt_idx;
                wr_addr  <= gnt_addr;
            end else begin
                wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREGS=6 so out-of-range addresses exist).
// Expected write commits and read data go into queues; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

    localparam int NREQ  = 4;
    localparam int NREGS = 6;
    localparam int AW    = 3;
    localparam int W     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*W-1:0] req_data;
    logic [AW-1:0]     rd_addr;
    logic [W-1:0]      rd_data;
    logic              wr_valid;
    logic [2:0]        wr_id;
    logic [AW-1:0]     wr_addr;

    logic [5:0]        exp_q[$];     // {wr_id, wr_addr}
    logic [W-1:0]      rd_exp_q[$];
    logic              rd_chk;
    logic              rd_chk_q;
    int                checks = 0;
    int                fails  = 0;

    regfile_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_id(wr_id), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_chk_q <= rd_chk;

    always @(negedge clk) begin
        if (rst_n && wr_valid) begin
            if (exp_q.size() == 0) check("wr_unexpected", 32'(wr_valid), 32'd0);
            else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("wr_id", 32'(wr_id), 32'(e[5:3]));
                check("wr_addr", 32'(wr_addr), 32'(e[2:0]));
            end
        end
        if (rst_n && rd_chk_q) begin
            if (rd_exp_q.size() == 0) check("rd_unexpected", 32'(rd_chk_q), 32'd0);
            else check("rd_data", 32'(rd_data), 32'(rd_exp_q.pop_front()));
        end
    end

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i]        = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*W +: W]   = d;
    endtask

    task automatic drop_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic read_expect(input logic [AW-1:0] a, input logic [W-1:0] e);
        rd_addr = a;
        rd_chk  = 1'b1;
        rd_exp_q.push_back(e);
    endtask

    task automatic expect_grant(input string name, input logic [NREQ-1:0] rdy,
                                input logic [2:0] id, input logic [AW-1:0] a);
        #1;
        check(name, 32'(req_ready), 32'(rdy));
        exp_q.push_back({id, a});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rd_chk = 1'b0;
    endtask

    initial begin
        logic [W-1:0] fin [8];
        logic [W-1:0] rdw_exp;
        fin = '{16'h0F0F, 16'h1234, 16'h5678, 16'h2222, 16'hC002, 16'hBEEF, 16'h0000, 16'h0000};
`ifdef REGFILE_ARB_BYPASS_EN
        rdw_exp = 16'h2222;
`else
        rdw_exp = 16'h1111;
`endif
        rst_n = 1'b1;
        rd_chk = 1'b0;
        rd_addr = '0;
        clear_reqs();

        // Asynchronous reset before the first edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_wr_valid", 32'(wr_valid), 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            read_expect(AW'(a), 16'h0000);
            step();
        end

        // Single writer, zero-cycle grant, then read back.
        set_req(2, 3'd5, 16'hBEEF);
        expect_grant("single_ready", 4'b0100, 3'd2, 3'd5);
        step();
        clear_reqs();
        read_expect(3'd5, 16'hBEEF);
        step();

        // Requester 3 alone moves the pointer to 0.
        set_req(3, 3'd4, 16'h3333);
        expect_grant("ptr_to0_ready", 4'b1000, 3'd3, 3'd4);
        step();
        clear_reqs();

        // Full load: grants rotate 0,1,2,3,0,1,2,3.
        for (int c = 0; c < 8; c++) begin
            int g;
            int r;
            g = c % 4;
            r = c / 4;
            for (int i = 0; i < NREQ; i++)
                set_req(i, AW'(i), 16'hA000 | 16'(((i < g) ? r + 1 : r) << 4) | 16'(i));
            expect_grant("rr_ready", NREQ'(1) << g, 3'(g), AW'(g));
            step();
        end
        clear_reqs();
        for (int a = 0; a < 4; a++) begin
            read_expect(AW'(a), 16'hA010 | 16'(a));
            step();
        end

        // Pointer skip: rr_ptr=1, valid=1001 -> 3 then 0.
        set_req(0, 3'd0, 16'h0F0F);
        expect_grant("skip_pre_ready", 4'b0001, 3'd0, 3'd0);
        step();
        clear_reqs();
        set_req(0, 3'd1, 16'h1234);
        set_req(3, 3'd2, 16'h5678);
        expect_grant("skip_ready", 4'b1000, 3'd3, 3'd2);
        step();
        drop_req(3);
        expect_grant("skip_next_ready", 4'b0001, 3'd0, 3'd1);
        step();
        clear_reqs();

        // Read-during-write on address 3.
        set_req(1, 3'd3, 16'h1111);
        expect_grant("rdw_old_ready", 4'b0010, 3'd1, 3'd3);
        step();
        clear_reqs();
        set_req(2, 3'd3, 16'h2222);
        expect_grant("rdw_new_ready", 4'b0100, 3'd2, 3'd3);
        read_expect(3'd3, rdw_exp);
        step();
        clear_reqs();
        read_expect(3'd3, 16'h2222);
        step();

        // Out-of-range address 7: handshake completes, bank untouched.
        set_req(3, 3'd7, 16'hFFFF);
        expect_grant("oor_ready", 4'b1000, 3'd3, 3'd7);
        read_expect(3'd7, 16'h0000);
        step();
        clear_reqs();

        // Two requesters on one address serialize; the later grant wins.
        set_req(0, 3'd4, 16'hC000);
        set_req(2, 3'd4, 16'hC002);
        expect_grant("coll_first_ready", 4'b0001, 3'd0, 3'd4);
        step();
        drop_req(0);
        expect_grant("coll_second_ready", 4'b0100, 3'd2, 3'd4);
        step();
        clear_reqs();

        for (int a = 0; a < 8; a++) begin
            read_expect(AW'(a), fin[a]);
            step();
        end

        // Reset in the middle of a pending request.
        read_expect(3'd5, 16'hBEEF);
        step();
        @(negedge clk);
        #1;
        set_req(1, 3'd5, 16'h7777);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_rd_data", 32'(rd_data), 32'h0);
        check("midrst_wr_valid", 32'(wr_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        clear_reqs();
        rst_n = 1'b1;
        read_expect(3'd5, 16'h0000);
        step();
        step();
        step();

        check("wr_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
